// File: rtl/btn_debouncer.sv
// rtl/btn_debouncer.sv - two-flop synchronised, counter-timed push-button debouncer
module btn_debouncer #(
    parameter int STABLE_CYCLES = 2_000_000,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic db,
    output logic busy
);

    // Terminal count: the candidate level has been seen on STABLE_CYCLES consecutive edges
    // once cnt reaches this value and the input is still at the candidate level.
    localparam logic [CNT_W-1:0] TERM = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        LOW     = 2'b00,
        WAIT_HI = 2'b01,
        HIGH    = 2'b11,
        WAIT_LO = 2'b10
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             s1;
    logic             s2;

    // Two-flop synchroniser; s2 is the only view of the button the FSM ever sees.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // Debounce FSM: time each candidate transition, abort on any opposite sample,
    // and drive db/busy as registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOW;
            cnt   <= '0;
            db    <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                LOW: begin
                    if (s2) begin
                        state <= WAIT_HI;
                        cnt   <= ONE;
                        busy  <= 1'b1;
                    end else begin
                        cnt   <= '0;
                    end
                end
                WAIT_HI: begin
                    if (!s2) begin
                        state <= LOW;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == TERM) begin
                        state <= HIGH;
                        cnt   <= '0;
                        db    <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        cnt   <= cnt + ONE;
                    end
                end
                HIGH: begin
                    if (!s2) begin
                        state <= WAIT_LO;
                        cnt   <= ONE;
                        busy  <= 1'b1;
                    end else begin
                        cnt   <= '0;
                    end
                end
                WAIT_LO: begin
                    if (s2) begin
                        state <= HIGH;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == TERM) begin
                        state <= LOW;
                        cnt   <= '0;
                        db    <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        cnt   <= cnt + ONE;
                    end
                end
                default: begin
                    state <= LOW;
                    cnt   <= '0;
                    db    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
